// File: rtl/yarvi_pkg.sv
// Shared RV64I decode constants, instruction-format enum and decode helpers.
// `VMSB (PC MSB) normally comes from yarvi.h; a default is supplied when absent.
`ifndef VMSB
`define VMSB 63
`endif

package yarvi_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    function automatic fmt_e insn_fmt(input logic [31:0] insn);
        fmt_e f;
        if (insn[1:0] != 2'b11) begin
            f = FMT_ILL;
        end else begin
            case (insn[6:0])
                OP_OP, OP_OP_32:                               f = FMT_R;
                OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_OP_IMM_32,
                OP_JALR, OP_SYSTEM:                            f = FMT_I;
                OP_STORE:                                      f = FMT_S;
                OP_BRANCH:                                     f = FMT_B;
                OP_LUI, OP_AUIPC:                              f = FMT_U;
                OP_JAL:                                        f = FMT_J;
                default:                                       f = FMT_ILL;
            endcase
        end
        return f;
    endfunction

    function automatic logic [63:0] insn_imm(input logic [31:0] insn);
        logic [63:0] imm;
        case (insn_fmt(insn))
            FMT_I:   imm = {{52{insn[31]}}, insn[31:20]};
            FMT_S:   imm = {{52{insn[31]}}, insn[31:25], insn[11:7]};
            FMT_B:   imm = {{51{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            FMT_U:   imm = {{32{insn[31]}}, insn[31:12], 12'h000};
            FMT_J:   imm = {{43{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = 64'd0;
        endcase
        return imm;
    endfunction

    // Stores, branches, fences and system ops never write a destination register.
    function automatic logic [4:0] insn_rd(input logic [31:0] insn);
        logic [4:0] rd;
        case (insn_fmt(insn))
            FMT_S, FMT_B: rd = 5'd0;
            default: begin
                if (insn[6:0] == OP_MISC_MEM || insn[6:0] == OP_SYSTEM) begin
                    rd = 5'd0;
                end else begin
                    rd = insn[11:7];
                end
            end
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/yarvi_de_if.sv
// Fetch -> decode -> execute handshake plus register-file write-back bundle.
`ifndef VMSB
`define VMSB 63
`endif

interface yarvi_de_if;
    logic              restart;
    logic              fe_valid;
    logic [`VMSB:0]    fe_pc;
    logic [31:0]       fe_insn;
    logic              de_ready;
    logic              ex_ready;
    logic              de_valid;
    logic [`VMSB:0]    de_pc;
    logic [31:0]       de_insn;
    logic [4:0]        de_rd;
    logic              de_illegal;
    logic [63:0]       de_rs1_val;
    logic [63:0]       de_rs2_val;
    logic [63:0]       de_imm;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [63:0]       wb_val;

    modport master (
        output restart, fe_valid, fe_pc, fe_insn, ex_ready, wb_we, wb_rd, wb_val,
        input  de_ready, de_valid, de_pc, de_insn, de_rd, de_illegal,
               de_rs1_val, de_rs2_val, de_imm
    );

    modport slave (
        input  restart, fe_valid, fe_pc, fe_insn, ex_ready, wb_we, wb_rd, wb_val,
        output de_ready, de_valid, de_pc, de_insn, de_rd, de_illegal,
               de_rs1_val, de_rs2_val, de_imm
    );
endinterface

// File: rtl/yarvi_regfile.sv
// 32x64 integer register file: two asynchronous read ports, one write port, x0 hardwired to zero.
module yarvi_regfile
    import yarvi_pkg::*;
(
    input  logic              i_clk,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    output logic [XLEN-1:0]   o_rs1_val,
    output logic [XLEN-1:0]   o_rs2_val,
    input  logic              i_we,
    input  logic [4:0]        i_wr,
    input  logic [XLEN-1:0]   i_wval
);
    logic [XLEN-1:0] r_regs [0:31];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we && i_wr != 5'd0) begin
            r_regs[i_wr] <= i_wval;
        end
    end

    assign o_rs1_val = (i_rs1 == 5'd0) ? 64'd0 : r_regs[i_rs1];
    assign o_rs2_val = (i_rs2 == 5'd0) ? 64'd0 : r_regs[i_rs2];
endmodule

// File: rtl/yarvi_de.sv
// Decode stage: 2-entry instruction buffer, RV64I field decode and register read.
// Optional YARVI_DE_WB_BYPASS_EN forwards same-cycle write-back data to the read values.
`ifndef VMSB
`define VMSB 63
`endif

module yarvi_de
    import yarvi_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    yarvi_de_if.slave   bus
);
    logic [1:0]       r_count;
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic             r_de_ready;
    logic [`VMSB:0]   r_pc   [0:1];
    logic [31:0]      r_insn [0:1];

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;
    logic             w_ready_nxt;
    logic [31:0]      w_head;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [XLEN-1:0]  w_rf_rs1;
    logic [XLEN-1:0]  w_rf_rs2;

    assign w_push = bus.fe_valid & r_de_ready & ~bus.restart;
    assign w_pop  = (r_count != 2'd0) & bus.ex_ready;

    // Next occupancy and ready; ready drops early so the fetch's one-cycle stop lag still fits.
    always_comb begin
        w_count_nxt = r_count;
        w_ready_nxt = r_de_ready;
        if (bus.restart) begin
            w_count_nxt = 2'd0;
            w_ready_nxt = 1'b1;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
            w_ready_nxt = (w_count_nxt == 2'd0) || ((w_count_nxt == 2'd1) && !w_push);
        end
    end

    // Buffer storage, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_de_ready <= 1'b1;
            r_pc[0]    <= {(`VMSB+1){1'b0}};
            r_pc[1]    <= {(`VMSB+1){1'b0}};
            r_insn[0]  <= 32'd0;
            r_insn[1]  <= 32'd0;
        end else begin
            r_count    <= w_count_nxt;
            r_de_ready <= w_ready_nxt;
            if (bus.restart) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_pc[r_wr_ptr]   <= bus.fe_pc;
                    r_insn[r_wr_ptr] <= bus.fe_insn;
                    r_wr_ptr         <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    assign w_head         = r_insn[r_rd_ptr];
    assign w_rs1          = w_head[19:15];
    assign w_rs2          = w_head[24:20];
    assign bus.de_ready   = r_de_ready;
    assign bus.de_valid   = (r_count != 2'd0);
    assign bus.de_pc      = r_pc[r_rd_ptr];
    assign bus.de_insn    = w_head;
    assign bus.de_rd      = insn_rd(w_head);
    assign bus.de_imm     = insn_imm(w_head);
    // Stale buffer contents must never flag illegal while the buffer is empty.
    assign bus.de_illegal = bus.de_valid & (insn_fmt(w_head) == FMT_ILL);

    yarvi_regfile u_regfile (
        .i_clk     (clock),
        .i_rs1     (w_rs1),
        .i_rs2     (w_rs2),
        .o_rs1_val (w_rf_rs1),
        .o_rs2_val (w_rf_rs2),
        .i_we      (bus.wb_we),
        .i_wr      (bus.wb_rd),
        .i_wval    (bus.wb_val)
    );

`ifdef YARVI_DE_WB_BYPASS_EN
    // Forward the write-back value for a matching, non-zero source register.
    always_comb begin
        bus.de_rs1_val = w_rf_rs1;
        bus.de_rs2_val = w_rf_rs2;
        if (bus.wb_we && (bus.wb_rd == w_rs1) && (w_rs1 != 5'd0)) begin
            bus.de_rs1_val = bus.wb_val;
        end else begin
            bus.de_rs1_val = w_rf_rs1;
        end
        if (bus.wb_we && (bus.wb_rd == w_rs2) && (w_rs2 != 5'd0)) begin
            bus.de_rs2_val = bus.wb_val;
        end else begin
            bus.de_rs2_val = w_rf_rs2;
        end
    end
`else
    assign bus.de_rs1_val = w_rf_rs1;
    assign bus.de_rs2_val = w_rf_rs2;
`endif

endmodule

// File: tb/tb_yarvi_de.sv
// Directed self-checking bench for yarvi_de: buffer flow control, restart, decode, register read.
`ifndef VMSB
`define VMSB 63
`endif

module tb_yarvi_de;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    yarvi_de_if bus ();

    yarvi_de dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [63:0] pc, input logic [31:0] insn);
        bus.fe_valid = 1'b1;
        bus.fe_pc    = pc[`VMSB:0];
        bus.fe_insn  = insn;
        step();
        bus.fe_valid = 1'b0;
    endtask

    initial begin
        bus.restart  = 1'b0;
        bus.fe_valid = 1'b0;
        bus.fe_pc    = '0;
        bus.fe_insn  = 32'd0;
        bus.ex_ready = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_val   = 64'd0;

        #12;
        chk("rst_valid",   64'(bus.de_valid),   64'd0);
        chk("rst_ready",   64'(bus.de_ready),   64'd1);
        chk("rst_pc",      64'(bus.de_pc),      64'd0);
        chk("rst_insn",    64'(bus.de_insn),    64'd0);
        chk("rst_imm",     bus.de_imm,          64'd0);
        chk("rst_rd",      64'(bus.de_rd),      64'd0);
        chk("rst_illegal", 64'(bus.de_illegal), 64'd0);
        reset = 1'b0;

        // addi x1,x0,5 flows through with latency 1
        bus.ex_ready = 1'b1;
        load(64'h200, 32'h00500093);
        chk("addi_valid",   64'(bus.de_valid),   64'd1);
        chk("addi_pc",      64'(bus.de_pc),      64'h200);
        chk("addi_rd",      64'(bus.de_rd),      64'd1);
        chk("addi_imm",     bus.de_imm,          64'd5);
        chk("addi_illegal", 64'(bus.de_illegal), 64'd0);
        chk("addi_rs1",     bus.de_rs1_val,      64'd0);
        chk("addi_ready",   64'(bus.de_ready),   64'd0);
        step();
        chk("drain_valid",  64'(bus.de_valid),   64'd0);
        chk("drain_ready",  64'(bus.de_ready),   64'd1);

        // Stalled execute: fetch holds its PC while de_ready is low
        bus.ex_ready = 1'b0;
        bus.fe_valid = 1'b1;
        bus.fe_insn  = 32'h00500093;
        bus.fe_pc    = 64'h300;
        step();
        chk("stall1_ready", 64'(bus.de_ready), 64'd0);
        chk("stall1_pc",    64'(bus.de_pc),    64'h300);
        bus.fe_pc = 64'h304;
        step();
        chk("stall2_ready", 64'(bus.de_ready), 64'd1);
        chk("stall2_valid", 64'(bus.de_valid), 64'd1);
        chk("stall2_pc",    64'(bus.de_pc),    64'h300);
        step();
        chk("stall3_ready", 64'(bus.de_ready), 64'd0);
        chk("stall3_pc",    64'(bus.de_pc),    64'h300);
        bus.fe_pc = 64'h308;
        step();
        chk("full_ready",   64'(bus.de_ready), 64'd0);
        chk("full_pc",      64'(bus.de_pc),    64'h300);
        chk("full_valid",   64'(bus.de_valid), 64'd1);
        bus.fe_valid = 1'b0;
        bus.ex_ready = 1'b1;
        step();
        chk("order_pc",     64'(bus.de_pc),    64'h304);
        chk("order_valid",  64'(bus.de_valid), 64'd1);
        chk("order_ready",  64'(bus.de_ready), 64'd1);
        bus.ex_ready = 1'b0;
        load(64'h308, 32'h00500093);
        chk("refill_pc",    64'(bus.de_pc),    64'h304);
        chk("refill_ready", 64'(bus.de_ready), 64'd0);

        // Restart on a full buffer, then restart while ready with fetch input present
        bus.restart  = 1'b1;
        bus.fe_valid = 1'b1;
        bus.fe_pc    = 64'h500;
        step();
        chk("rs_valid", 64'(bus.de_valid), 64'd0);
        chk("rs_ready", 64'(bus.de_ready), 64'd1);
        bus.fe_pc = 64'h600;
        step();
        chk("rs2_valid", 64'(bus.de_valid), 64'd0);
        chk("rs2_ready", 64'(bus.de_ready), 64'd1);
        bus.restart  = 1'b0;
        bus.fe_valid = 1'b0;
        step();
        chk("rs_drop_valid", 64'(bus.de_valid), 64'd0);

        // jal x1,8 then lui x5,0x80000 pushed while jal is popped
        bus.ex_ready = 1'b0;
        load(64'hA00, 32'h008000EF);
        chk("jal_imm", bus.de_imm,       64'd8);
        chk("jal_rd",  64'(bus.de_rd),   64'd1);
        bus.fe_valid = 1'b1;
        bus.fe_pc    = 64'hA04;
        bus.fe_insn  = 32'h800002B7;
        step();
        chk("hold_pc",    64'(bus.de_pc),    64'hA00);
        chk("hold_ready", 64'(bus.de_ready), 64'd1);
        bus.ex_ready = 1'b1;
        step();
        bus.fe_valid = 1'b0;
        chk("pp_pc",    64'(bus.de_pc),    64'hA04);
        chk("pp_valid", 64'(bus.de_valid), 64'd1);
        chk("pp_ready", 64'(bus.de_ready), 64'd0);
        chk("lui_imm",  bus.de_imm,        64'hFFFFFFFF80000000);
        chk("lui_rd",   64'(bus.de_rd),    64'd5);
        step();
        chk("pp_drain", 64'(bus.de_valid), 64'd0);

        // Decode corner cases
        load(64'hB00, 32'hFFFFFFFF);
        chk("ill_flag", 64'(bus.de_illegal), 64'd1);
        step();
        load(64'hB04, 32'hFE000EE3);
        chk("beq_imm", bus.de_imm,       64'hFFFFFFFFFFFFFFFC);
        chk("beq_rd",  64'(bus.de_rd),   64'd0);
        chk("beq_ill", 64'(bus.de_illegal), 64'd0);
        step();
        load(64'hB08, 32'hFE20BC23);
        chk("sd_imm", bus.de_imm,     64'hFFFFFFFFFFFFFFF8);
        chk("sd_rd",  64'(bus.de_rd), 64'd0);
        step();

        // Write-back of x3 while add x4,x3,x3 waits at the head
        bus.ex_ready = 1'b0;
        load(64'h800, 32'h00318233);
        chk("add_rd",  64'(bus.de_rd), 64'd4);
        chk("add_imm", bus.de_imm,     64'd0);
        bus.wb_we  = 1'b1;
        bus.wb_rd  = 5'd3;
        bus.wb_val = 64'hDEAD;
        #1;
`ifdef YARVI_DE_WB_BYPASS_EN
        chk("byp_rs1", bus.de_rs1_val, 64'hDEAD);
        chk("byp_rs2", bus.de_rs2_val, 64'hDEAD);
`endif
        step();
        bus.wb_we = 1'b0;
        #1;
        chk("wb_rs1", bus.de_rs1_val, 64'hDEAD);
        chk("wb_rs2", bus.de_rs2_val, 64'hDEAD);
        bus.ex_ready = 1'b1;
        step();

        // Writes to x0 are ignored: add x1,x0,x0 reads zero
        bus.ex_ready = 1'b0;
        load(64'h900, 32'h000000B3);
        bus.wb_we  = 1'b1;
        bus.wb_rd  = 5'd0;
        bus.wb_val = 64'h1234;
        #1;
        chk("x0_same_rs1", bus.de_rs1_val, 64'd0);
        step();
        bus.wb_we = 1'b0;
        #1;
        chk("x0_rs1", bus.de_rs1_val, 64'd0);
        chk("x0_rs2", bus.de_rs2_val, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/yarvi_de.md
YARVI_DE -- requirements
Module: yarvi_de

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port restart, input, 1, pipeline flush from the redirect source.
REQ-004 SHALL have port fe_valid, input, 1, fetch slot holds an instruction.
REQ-005 SHALL have port fe_pc, input, `VMSB+1, PC of fetched instruction.
REQ-006 SHALL have port fe_insn, input, 32, fetched instruction word.
REQ-007 SHALL have port de_ready, output, 1, registered; fetch SHALL hold PC while low.
REQ-008 SHALL have port ex_ready, input, 1, execute consumes head this cycle.
REQ-009 SHALL have ports de_valid (1), de_pc (`VMSB+1), de_insn (32), de_rd (5), de_illegal (1), all outputs describing the buffer head.
REQ-010 SHALL have ports de_rs1_val, de_rs2_val, de_imm, outputs, 64 each.
REQ-011 SHALL have ports wb_we (1), wb_rd (5), wb_val (64), inputs, register-file write port.

Function
REQ-012 SHALL hold fetched instructions in a 2-entry FIFO (count 0..2); push = fe_valid & de_ready & ~restart; pop = de_valid & ex_ready.
REQ-013 SHALL register de_ready as (next count == 0) or (next count == 1 and no push this cycle), covering one-cycle fetch stop latency without loss.
REQ-014 SHALL present a pushed instruction at the head the cycle after push when the FIFO was empty or popped (latency 1).
REQ-015 SHALL allow push and pop in the same cycle; count unchanged, order preserved, pointer wrap mod 2.
REQ-016 SHALL hold head outputs stable while de_valid & ~ex_ready.
REQ-017 SHALL on restart empty the FIFO so de_valid = 0 the next cycle, discard that cycle's fe input, and leave de_ready = 1.
REQ-018 SHALL decode de_rd = insn[11:7], forced to 0 for S, B, and FENCE/ECALL formats.
REQ-019 SHALL form de_imm sign-extended to 64 bits per I/S/B/U/J format; 0 for R-type.
REQ-020 SHALL assert de_illegal when the head opcode is outside RV64I base opcodes or insn[1:0] != 2'b11.
REQ-021 SHALL read de_rs1_val/de_rs2_val from a 32x64 register file using head rs1/rs2; x0 reads 0.
REQ-022 SHALL write the register file on wb_we at posedge; writes to x0 ignored.

Reset
REQ-023 SHALL on reset clear count and pointers, de_valid = 0, de_ready = 1; de_pc, de_insn, de_imm, de_rd = 0; de_illegal = 0.
REQ-024 SHALL not reset register-file contents; reset mid-operation drops all buffered instructions.

Configuration
REQ-025 SHALL use macro YARVI_DE_WB_BYPASS_EN.
REQ-026 With YARVI_DE_WB_BYPASS_EN: wb_we & wb_rd == rsN & rsN != 0 SHALL drive wb_val onto de_rsN_val in the same cycle.
REQ-027 Without it: written value SHALL appear on de_rsN_val from the following cycle only.

Structure
REQ-028 SHALL place opcode constants, format enum, and XLEN = 64 in shared package yarvi_pkg; PC width keeps `VMSB from yarvi.h.
REQ-029 SHALL implement the register file as sub-module yarvi_regfile (2 async read ports, 1 write port).

Verification
REQ-030 Reset, then fe_valid = 1, fe_pc = 0x200, fe_insn = 0x00500093 (addi x1,x0,5), ex_ready = 1 -> next cycle de_valid = 1, de_pc = 0x200, de_rd = 1, de_imm = 5.
REQ-031 ex_ready = 0 with 3 consecutive pushes -> de_ready falls after count 1, exactly 2 entries kept; head de_pc = first PC, held stable.
REQ-032 Full FIFO plus restart = 1 -> next cycle de_valid = 0, de_ready = 1; the restart-cycle fe input never appears.
REQ-033 wb_we = 1, wb_rd = 3, wb_val = 0xDEAD with head add x4,x3,x3 -> with macro, de_rs1_val = de_rs2_val = 0xDEAD the same cycle; without macro, 0xDEAD one cycle later.
REQ-034 fe_insn = 0xFFFFFFFF -> de_illegal = 1; fe_insn = 0xFE000EE3 (beq x0,x0,-4) -> de_imm = 0xFFFFFFFFFFFFFFFC, de_rd = 0.
REQ-035 wb_we to x0 with 0x1234 then read x0 -> de_rs1_val = 0.
